// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: op codes, FSM encoding and default sizes shared by the JK sequencer slice
package jk_seq_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 4;
  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_COUNT  = 3'd5;
  localparam logic [2:0] OP_SHIFT  = 3'd6;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
  // COUNT and SHIFT run for Cmd_count edges; everything else is a single step
  function automatic logic is_multi(input logic [2:0] op);
    return op == OP_COUNT || op == OP_SHIFT;
  endfunction
endpackage

// File: rtl/jk_reg_sequencer_if.sv
// jk_reg_sequencer_if: command handshake and bank status bundle
interface jk_reg_sequencer_if
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  logic             Cmd_valid;
  logic             Cmd_ready;
  logic [2:0]       Cmd_op;
  logic [WIDTH-1:0] Cmd_data;
  logic [CNT_W-1:0] Cmd_count;
  logic [WIDTH-1:0] Q;
  logic             Busy;
  logic             Done;
  logic             Ovf;
  modport master (
    output Cmd_valid, Cmd_op, Cmd_data, Cmd_count,
    input  Cmd_ready, Q, Busy, Done, Ovf
  );
  modport slave (
    input  Cmd_valid, Cmd_op, Cmd_data, Cmd_count,
    output Cmd_ready, Q, Busy, Done, Ovf
  );
endinterface

// File: rtl/jk_cell.sv
// jk_cell: single falling-edge JK flip-flop with asynchronous active-high reset to 0
module jk_cell (
  input  logic CLK,
  input  logic Reset,
  input  logic j,
  input  logic k,
  output logic q
);
  // hold on 00, reset on 01, set on 10, toggle on 11
  always_ff @(negedge CLK or posedge Reset)
    if (Reset) q <= 1'b0;
    else q <= (j & ~q) | (~k & q);
endmodule

// File: rtl/jk_reg_sequencer.sv
// jk_reg_sequencer: command-driven J/K sequencer over a bank of jk_cell; JK_SEQ_SATURATE_EN makes COUNT saturate and flag Ovf
module jk_reg_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic CLK,
  input logic Reset,
  jk_reg_sequencer_if.slave bus
);
  state_t state, nxt;
  logic [2:0] op;
  logic [WIDTH-1:0] data, q, j, k, carry;
  logic [CNT_W-1:0] rem;
  logic accept, zero_cnt, sat, run;
  assign accept = state == IDLE && bus.Cmd_valid;
  assign zero_cnt = is_multi(bus.Cmd_op) && bus.Cmd_count == '0;
  // state register, falling edge
  always_ff @(negedge CLK or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= nxt;
  // next state: zero-count multi-step commands skip straight to DONE
  always_comb
    nxt = state == IDLE ? (bus.Cmd_valid ? (zero_cnt ? DONE : EXEC) : IDLE) :
          state == EXEC ? (rem == CNT_W'(1) ? DONE : EXEC) : IDLE;
  // command capture on the accept edge; remaining steps count down during EXEC
  always_ff @(negedge CLK or posedge Reset)
    if (Reset) begin
      op <= OP_NOP;
      data <= '0;
      rem <= '0;
    end else if (accept) begin
      op <= bus.Cmd_op;
      data <= bus.Cmd_data;
      rem <= is_multi(bus.Cmd_op) ? bus.Cmd_count : CNT_W'(1);
    end else if (state == EXEC) rem <= rem - CNT_W'(1);
  // up-count toggle enables: bit i toggles when all lower bits are ones
  always_comb begin
    carry = '0;
    run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i] = run;
      run = run & q[i];
    end
  end
`ifdef JK_SEQ_SATURATE_EN
  logic ovf;
  assign sat = op == OP_COUNT && &q;
  // overflow flag: cleared by a new accept, set by a saturated COUNT step
  always_ff @(negedge CLK or posedge Reset)
    if (Reset) ovf <= 1'b0;
    else if (accept) ovf <= 1'b0;
    else if (state == EXEC && sat) ovf <= 1'b1;
  assign bus.Ovf = ovf;
`else
  assign sat = 1'b0;
  assign bus.Ovf = 1'b0;
`endif
  // J/K decode: only EXEC drives the bank, all other states hold
  always_comb begin
    j = '0;
    k = '0;
    if (state == EXEC && !sat)
      case (op)
        OP_CLEAR: k = '1;
        OP_SET: j = '1;
        OP_LOAD: begin
          j = data;
          k = ~data;
        end
        OP_TOGGLE: begin
          j = data;
          k = data;
        end
        OP_COUNT: begin
          j = carry;
          k = carry;
        end
        OP_SHIFT: begin
          j = {q[WIDTH-2:0], 1'b0};
          k = ~{q[WIDTH-2:0], 1'b0};
        end
        default: ;
      endcase
  end
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (.CLK(CLK), .Reset(Reset), .j(j[g]), .k(k[g]), .q(q[g]));
  end
  // status decoded from registered state only
  always_comb begin
    bus.Cmd_ready = state == IDLE;
    bus.Busy = state == EXEC;
    bus.Done = state == DONE;
    bus.Q = q;
  end
endmodule

// File: tb/tb_jk_reg_sequencer.sv
// tb_jk_reg_sequencer: directed scoreboard bench for jk_reg_sequencer
module tb_jk_reg_sequencer;
  import jk_seq_pkg::*;
`ifdef JK_SEQ_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct packed {
    logic [3:0] q;
    logic ovf;
  } exp_t;
  logic clk = 1'b1;
  logic rst = 1'b1;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int dones = 0;
  logic [3:0] mq = 4'h0;
  logic movf = 1'b0;
  always #5 clk = ~clk;
  jk_reg_sequencer_if #(.WIDTH(4), .CNT_W(4)) bus ();
  jk_reg_sequencer #(.WIDTH(4), .CNT_W(4)) dut (.CLK(clk), .Reset(rst), .bus(bus));
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  function automatic logic [3:0] step(input logic [2:0] op, input logic [3:0] d, input logic [3:0] q);
    case (op)
      OP_CLEAR: return 4'h0;
      OP_SET: return 4'hf;
      OP_LOAD: return d;
      OP_TOGGLE: return q ^ d;
      OP_COUNT: return (SAT && q == 4'hf) ? q : q + 4'h1;
      OP_SHIFT: return q << 1;
      default: return q;
    endcase
  endfunction
  always @(posedge clk)
    if (bus.Done === 1'b1) begin
      exp_t e;
      dones++;
      check("done_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("done_q", bus.Q, e.q);
        check("done_ovf", bus.Ovf, e.ovf);
      end
    end
  task automatic send(input logic [2:0] op, input logic [3:0] d, input logic [3:0] c);
    int steps = (op == OP_COUNT || op == OP_SHIFT) ? int'(c) : 1;
    int w = 0;
    logic [3:0] t = mq;
    logic o = 1'b0;
    for (int s = 0; s < steps; s++) begin
      if (op == OP_COUNT && SAT && t == 4'hf) o = 1'b1;
      t = step(op, d, t);
    end
    sb.push_back('{q: t, ovf: o});
    while (bus.Cmd_ready !== 1'b1 && w < 20) begin
      @(posedge clk);
      w++;
    end
    check("ready_wait", bus.Cmd_ready, 1);
    bus.Cmd_valid = 1'b1;
    bus.Cmd_op = op;
    bus.Cmd_data = d;
    bus.Cmd_count = c;
    @(negedge clk);
    @(posedge clk);
    bus.Cmd_valid = 1'b0;
    movf = 1'b0;
    for (int s = 0; s < steps; s++) begin
      check("busy", bus.Busy, 1);
      check("ready_low", bus.Cmd_ready, 0);
      check("step_q", bus.Q, mq);
      bus.Cmd_data = 4'($urandom);
      bus.Cmd_count = 4'($urandom);
      if (op == OP_COUNT && SAT && mq == 4'hf) movf = 1'b1;
      mq = step(op, d, mq);
      @(posedge clk);
    end
    check("done_high", bus.Done, 1);
    @(posedge clk);
    check("done_low", bus.Done, 0);
    check("ready_back", bus.Cmd_ready, 1);
    check("idle_q", bus.Q, mq);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int d0;
    bus.Cmd_valid = 1'b0;
    bus.Cmd_op = OP_NOP;
    bus.Cmd_data = 4'h0;
    bus.Cmd_count = 4'h0;
    repeat (2) @(posedge clk);
    check("rst_q", bus.Q, 0);
    check("rst_ready", bus.Cmd_ready, 1);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_ovf", bus.Ovf, 0);
    rst = 1'b0;
    @(posedge clk);
    bus.Cmd_valid = 1'b1;
    bus.Cmd_op = OP_COUNT;
    bus.Cmd_count = 4'd9;
    @(negedge clk);
    @(posedge clk);
    bus.Cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    check("mid_count_q", bus.Q, 3);
    check("mid_count_busy", bus.Busy, 1);
    rst = 1'b1;
    #1;
    check("abort_q", bus.Q, 0);
    check("abort_ready", bus.Cmd_ready, 1);
    check("abort_busy", bus.Busy, 0);
    check("abort_done", bus.Done, 0);
    @(posedge clk);
    rst = 1'b0;
    @(posedge clk);
    check("post_abort_done", bus.Done, 0);
    mq = 4'h0;
    send(OP_LOAD, 4'b1010, 4'd0);
    send(OP_LOAD, 4'b0110, 4'd0);
    send(OP_TOGGLE, 4'b0011, 4'd0);
    send(OP_SET, 4'h0, 4'd0);
    send(OP_COUNT, 4'h0, 4'd3);
    send(OP_LOAD, 4'b0011, 4'd0);
    send(OP_SHIFT, 4'h0, 4'd2);
    send(OP_COUNT, 4'h0, 4'd0);
    send(3'd7, 4'hf, 4'd5);
    send(OP_SHIFT, 4'h0, 4'd0);
    d0 = dones;
    for (int s = 0; s < 3; s++) begin
      mq = mq ^ 4'b0001;
      sb.push_back('{q: mq, ovf: 1'b0});
    end
    bus.Cmd_valid = 1'b1;
    bus.Cmd_op = OP_TOGGLE;
    bus.Cmd_data = 4'b0001;
    repeat (9) @(negedge clk);
    @(posedge clk);
    bus.Cmd_valid = 1'b0;
    check("b2b_dones", 8'(dones - d0), 3);
    check("b2b_ready", bus.Cmd_ready, 1);
    check("b2b_q", bus.Q, mq);
    send(OP_CLEAR, 4'h0, 4'd0);
    send(OP_NOP, 4'hf, 4'd0);
    send(OP_LOAD, 4'b1001, 4'd0);
    send(OP_SHIFT, 4'h0, 4'd4);
    send(OP_LOAD, 4'b1110, 4'd0);
    send(OP_COUNT, 4'h0, 4'd2);
    repeat (3) @(posedge clk);
    check("sb_empty", 8'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
